// File: rtl/conv_scan_if.sv
// Bus bundle between the conv scan engine (slave side) and its driver/core (master side).
// With CONV_PX_STREAM_EN defined, the pixel write stream signals are added.
interface conv_scan_if #(
    parameter int IMG_DIM = 28,
    parameter int WIN     = 6,
    parameter int STRIDE  = 2,
    parameter int N_CH    = 18
);
    localparam int OUT_DIM = (IMG_DIM - WIN) / STRIDE + 1;
    localparam int CW      = $clog2(OUT_DIM);

    logic                                        begin_conv;
    logic [N_CH-1:0]                             ch_en;
    logic [IMG_DIM-1:0][IMG_DIM-1:0]             image;
    logic [WIN-1:0][WIN-1:0]                     win_out;
    logic [N_CH-1:0]                             pixel_in;
    logic                                        busy;
    logic                                        done_conv;
    logic [OUT_DIM-1:0][OUT_DIM-1:0][N_CH-1:0]   out_fmap;
`ifdef CONV_PX_STREAM_EN
    logic                                        px_valid;
    logic [CW-1:0]                               px_row;
    logic [CW-1:0]                               px_col;
    logic [N_CH-1:0]                             px_data;

    modport master (output begin_conv, ch_en, image, pixel_in,
                    input  win_out, busy, done_conv, out_fmap,
                           px_valid, px_row, px_col, px_data);
    modport slave  (input  begin_conv, ch_en, image, pixel_in,
                    output win_out, busy, done_conv, out_fmap,
                           px_valid, px_row, px_col, px_data);
`else
    modport master (output begin_conv, ch_en, image, pixel_in,
                    input  win_out, busy, done_conv, out_fmap);
    modport slave  (input  begin_conv, ch_en, image, pixel_in,
                    output win_out, busy, done_conv, out_fmap);
`endif
endinterface

// File: rtl/conv_scan_engine.sv
// Window scan sequencer: walks a WIN x WIN window over the image, aligns the core result
// through a CORE_LAT delay line and stores it in out_fmap. Optional CONV_PX_STREAM_EN adds a write stream.
module conv_scan_engine #(
    parameter int IMG_DIM  = 28,
    parameter int WIN      = 6,
    parameter int STRIDE   = 2,
    parameter int N_CH     = 18,
    parameter int CORE_LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    conv_scan_if.slave bus
);
    localparam int OUT_DIM = (IMG_DIM - WIN) / STRIDE + 1;
    localparam int CW      = $clog2(OUT_DIM);
    localparam int IW      = $clog2(IMG_DIM);
    localparam int DW      = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   row_cnt, col_cnt;
    logic [DW-1:0]   drain_cnt;
    logic [N_CH-1:0] ch_en_q;
    logic            start, issue, col_last, last_pos;
    logic            wr_vld;
    logic [CW-1:0]   wr_row, wr_col;

    // Start is only honoured when no scan/drain is in flight; DONE may chain straight into a new run.
    assign start    = bus.begin_conv && (state == IDLE || state == DONE);
    assign issue    = (state == SCAN);
    assign col_last = (col_cnt == CW'(OUT_DIM - 1));
    assign last_pos = issue && col_last && (row_cnt == CW'(OUT_DIM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = SCAN;
            SCAN:  if (last_pos) state_nxt = (CORE_LAT == 0) ? DONE : DRAIN;
            DRAIN: if (drain_cnt == DW'(CORE_LAT - 1)) state_nxt = DONE;
            DONE:  state_nxt = start ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            col_cnt   <= '0;
            drain_cnt <= '0;
            ch_en_q   <= '0;
        end else begin
            if (start) begin
                row_cnt <= '0;
                col_cnt <= '0;
                ch_en_q <= bus.ch_en;
            end else if (issue) begin
                col_cnt <= col_last ? '0 : col_cnt + 1'b1;
                if (last_pos)      row_cnt <= '0;
                else if (col_last) row_cnt <= row_cnt + 1'b1;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    assign bus.busy      = (state == SCAN) || (state == DRAIN);
    assign bus.done_conv = (state == DONE);

    always_comb begin
        bus.win_out = '0;
        for (int x = 0; x < WIN; x++)
            for (int y = 0; y < WIN; y++)
                bus.win_out[x][y] = bus.image[IW'(int'(row_cnt) * STRIDE + x)]
                                             [IW'(int'(col_cnt) * STRIDE + y)];
    end

    // Issue valid and address ride alongside the core pipeline so the result lands at its position.
    generate
        if (CORE_LAT == 0) begin : g_nodly
            assign wr_vld = issue;
            assign wr_row = row_cnt;
            assign wr_col = col_cnt;
        end else begin : g_dly
            logic [CORE_LAT-1:0]         vld_pipe;
            logic [CORE_LAT-1:0][CW-1:0] row_pipe, col_pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    row_pipe <= '0;
                    col_pipe <= '0;
                end else begin
                    vld_pipe[0] <= issue;
                    row_pipe[0] <= row_cnt;
                    col_pipe[0] <= col_cnt;
                    for (int k = 1; k < CORE_LAT; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        row_pipe[k] <= row_pipe[k-1];
                        col_pipe[k] <= col_pipe[k-1];
                    end
                end
            end
            assign wr_vld = vld_pipe[CORE_LAT-1];
            assign wr_row = row_pipe[CORE_LAT-1];
            assign wr_col = col_pipe[CORE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      bus.out_fmap <= '0;
        else if (wr_vld) bus.out_fmap[wr_row][wr_col] <= bus.pixel_in & ch_en_q;
    end

`ifdef CONV_PX_STREAM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.px_valid <= 1'b0;
            bus.px_row   <= '0;
            bus.px_col   <= '0;
            bus.px_data  <= '0;
        end else begin
            bus.px_valid <= wr_vld;
            bus.px_row   <= wr_row;
            bus.px_col   <= wr_col;
            bus.px_data  <= bus.pixel_in & ch_en_q;
        end
    end
`endif
endmodule
